branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter: size, default 32, data/address width in bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ex_valid  input  1  EX-stage control-flow instruction present this cycle.
REQ-005 ex_pc  input  size  PC of the EX instruction.
REQ-006 ex_imm  input  size  sign-extended immediate.
REQ-007 ex_rs1, ex_rs2  input  size each  source operand values.
REQ-008 ex_funct3  input  3  branch condition code.
REQ-009 ex_is_branch, ex_is_jal, ex_is_jalr  input  1 each  instruction class.
REQ-010 ex_pred_taken  input  1  taken prediction made at fetch for this instruction.
REQ-011 redirect_ready  input  1  fetch accepts redirect this cycle.
REQ-012 redirect_valid  output  1  corrected PC offered to fetch.
REQ-013 redirect_pc  output  size  corrected fetch address.
REQ-014 flush  output  1  kill IF/ID contents.
REQ-015 stall  output  1  hold EX inputs stable; resolver busy.
REQ-016 mispredict_count  output  16  saturating count of redirects issued.

Function
REQ-017 Class priority when several class bits are set: jalr > jal > branch; none set -> not a control-flow instruction, no action.
REQ-018 Branch condition: funct3 000 rs1==rs2; 001 rs1!=rs2; 100 signed rs1<rs2; 101 signed rs1>=rs2; 110 unsigned rs1<rs2; 111 unsigned rs1>=rs2; 010/011 -> not taken.
REQ-019 actual_taken = jalr | jal | (branch & condition).
REQ-020 Target: jalr -> (rs1+imm) with bit 0 cleared; jal/branch taken -> pc+imm; not taken -> pc+4; all sums modulo 2^size.
REQ-021 Mispredict = ex_valid & class present & (jalr | actual_taken != ex_pred_taken); jalr always mispredicts (target unknown at fetch).
REQ-022 FSM states IDLE, REDIRECT, DRAIN.
REQ-023 IDLE: mispredict -> capture target into redirect_pc, increment mispredict_count (saturate at 0xFFFF), next REDIRECT; otherwise remain IDLE.
REQ-024 REDIRECT: redirect_valid=1, flush=1, stall=1; redirect_pc held stable; redirect_ready=1 -> DRAIN, else remain.
REQ-025 DRAIN: redirect_valid=0, flush=1, stall=1 for exactly one cycle, then IDLE.
REQ-026 IDLE outputs: redirect_valid=0, flush=0, stall=0.
REQ-027 ex_* inputs ignored in REDIRECT and DRAIN; no second redirect captured until IDLE.
REQ-028 Latency: mispredict in EX at cycle N -> redirect_valid/flush high at cycle N+1 (registered outputs only, no combinational input-to-output path).
REQ-029 Correct prediction (including not-taken branch predicted not taken) -> no outputs change, counter unchanged.

Reset
REQ-030 reset asserted at any time, including mid-REDIRECT: state=IDLE, redirect_valid=0, flush=0, stall=0, redirect_pc=0, mispredict_count=0 immediately, without waiting for clk.
REQ-031 First capture possible on the first rising edge after reset deasserts.

Verification
REQ-032 BEQ pc=0x100, imm=0x20, rs1=rs2=5, pred_taken=1 -> no redirect, count stays 0.
REQ-033 BNE pc=0x100, imm=0x20, rs1=rs2=5, pred_taken=1 -> next cycle redirect_valid=1, redirect_pc=0x104, flush=1; ready=1 -> one DRAIN cycle, then IDLE; count=1.
REQ-034 JALR rs1=0x1001, imm=0x10, pred_taken=0, redirect_ready low 3 cycles -> redirect_pc=0x1010 held stable with valid high 3 cycles, stall high throughout, accepted on 4th.
REQ-035 BLT rs1=0xFFFFFFFF, rs2=1 (signed -1<1 taken) vs BLTU same operands (not taken), both pred_taken=0 -> first redirects to pc+imm, second produces no redirect.
REQ-036 Wrap: JAL pc=0xFFFFFFFC, imm=0x8, pred_taken=1 -> no redirect; same with pred_taken=0 -> redirect_pc=0x00000004.
REQ-037 Reset pulse while in REDIRECT -> all outputs 0 asynchronously; count forced to 0xFFFF beforehand stays saturated on further mispredicts until reset.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch resolver: decides in EX whether a control-flow instruction was
// mispredicted at fetch, and if so hands the corrected PC to fetch while
// flushing IF/ID and stalling EX until the redirect has been accepted.
module branch_resolver #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [size-1:0] ex_pc,
  input  logic [size-1:0] ex_imm,
  input  logic [size-1:0] ex_rs1,
  input  logic [size-1:0] ex_rs2,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            ex_pred_taken,
  input  logic            redirect_ready,
  output logic            redirect_valid,
  output logic [size-1:0] redirect_pc,
  output logic            flush,
  output logic            stall,
  output logic [15:0]     mispredict_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t          state;
  logic            cond_met;
  logic            class_present;
  logic            actual_taken;
  logic            mispredict;
  logic [size-1:0] pc_plus_imm;
  logic [size-1:0] rs1_plus_imm;
  logic [size-1:0] pc_plus_4;
  logic [size-1:0] target;

  // Evaluate the branch condition from funct3; 010/011 never take.
  always_comb begin
    cond_met = 1'b0;
    case (ex_funct3)
      3'b000:  cond_met = (ex_rs1 == ex_rs2);
      3'b001:  cond_met = (ex_rs1 != ex_rs2);
      3'b100:  cond_met = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  cond_met = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cond_met = (ex_rs1 <  ex_rs2);
      3'b111:  cond_met = (ex_rs1 >= ex_rs2);
      default: cond_met = 1'b0;
    endcase
  end

  // Resolve direction and target; jalr outranks jal which outranks branch.
  // jalr always counts as a mispredict because fetch cannot know its target.
  always_comb begin
    pc_plus_imm   = ex_pc + ex_imm;
    rs1_plus_imm  = ex_rs1 + ex_imm;
    pc_plus_4     = ex_pc + size'(4);
    class_present = ex_is_jalr | ex_is_jal | ex_is_branch;
    actual_taken  = ex_is_jalr | ex_is_jal | (ex_is_branch & cond_met);
    if (ex_is_jalr) begin
      target = {rs1_plus_imm[size-1:1], 1'b0};
    end else if (actual_taken) begin
      target = pc_plus_imm;
    end else begin
      target = pc_plus_4;
    end
    mispredict = ex_valid & class_present &
                 (ex_is_jalr | (actual_taken != ex_pred_taken));
  end

  // Redirect FSM with registered outputs; EX inputs are only looked at in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      redirect_valid   <= 1'b0;
      flush            <= 1'b0;
      stall            <= 1'b0;
      redirect_pc      <= '0;
      mispredict_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mispredict) begin
            state          <= REDIRECT;
            redirect_pc    <= target;
            redirect_valid <= 1'b1;
            flush          <= 1'b1;
            stall          <= 1'b1;
            if (mispredict_count != 16'hFFFF) begin
              mispredict_count <= mispredict_count + 16'd1;
            end
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= DRAIN;
            redirect_valid <= 1'b0;
          end
        end
        DRAIN: begin
          state <= IDLE;
          flush <= 1'b0;
          stall <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          stall          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the resolver.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_imm = '0;
  logic [31:0] ex_rs1 = '0;
  logic [31:0] ex_rs2 = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_is_branch = 1'b0;
  logic        ex_is_jal = 1'b0;
  logic        ex_is_jalr = 1'b0;
  logic        ex_pred_taken = 1'b0;
  logic        redirect_ready = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        stall;
  logic [15:0] mispredict_count;

  int total = 0;
  int bad = 0;

  // model state
  bit          m_redir = 0;
  bit          m_drain = 0;
  logic [31:0] m_pc = '0;
  logic [15:0] m_cnt = '0;

  branch_resolver #(.size(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_funct3(ex_funct3), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_pred_taken(ex_pred_taken), .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .stall(stall), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // What the instruction really does, straight from the ISA rules.
  task automatic resolve(output bit mis, output logic [31:0] tgt);
    bit taken;
    longint sum;
    taken = 0;
    case (ex_funct3)
      3'd0: taken = (ex_rs1 == ex_rs2);
      3'd1: taken = (ex_rs1 != ex_rs2);
      3'd4: taken = (int'(ex_rs1) <  int'(ex_rs2));
      3'd5: taken = (int'(ex_rs1) >= int'(ex_rs2));
      3'd6: taken = (longint'(ex_rs1) <  longint'(ex_rs2));
      3'd7: taken = (longint'(ex_rs1) >= longint'(ex_rs2));
      default: taken = 0;
    endcase
    if (ex_is_jalr) begin
      sum = (longint'(ex_rs1) + longint'(ex_imm)) % 64'h1_0000_0000;
      tgt = 32'(sum) & 32'hFFFF_FFFE;
      mis = ex_valid;
    end else if (ex_is_jal) begin
      sum = (longint'(ex_pc) + longint'(ex_imm)) % 64'h1_0000_0000;
      tgt = 32'(sum);
      mis = ex_valid && !ex_pred_taken;
    end else if (ex_is_branch) begin
      sum = (longint'(ex_pc) + (taken ? longint'(ex_imm) : 64'd4)) % 64'h1_0000_0000;
      tgt = 32'(sum);
      mis = ex_valid && (taken != ex_pred_taken);
    end else begin
      tgt = '0;
      mis = 0;
    end
  endtask

  // One clock: update the model from the inputs present before the edge.
  task automatic tick();
    bit mis;
    logic [31:0] tgt;
    resolve(mis, tgt);
    if (m_redir) begin
      if (redirect_ready) begin
        m_redir = 0;
        m_drain = 1;
      end
    end else if (m_drain) begin
      m_drain = 0;
    end else if (mis) begin
      m_redir = 1;
      m_pc = tgt;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input bit br, input bit jal, input bit jalr,
                        input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] rs1,
                        input logic [31:0] rs2, input bit pred);
    ex_valid = 1; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; ex_rs2 = rs2;
    ex_pred_taken = pred;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({redirect_valid, flush, stall} !== 3'b000 || redirect_pc !== 32'h0 ||
        mispredict_count !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: got v/f/s=%b pc=%h cnt=%h, want 000 0 0",
               {redirect_valid, flush, stall}, redirect_pc, mispredict_count);
    end
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    $display("reset released");
  endtask

  task automatic test_beq_correct();
    set_ex(1, 0, 0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1);
    tick();
    clear_ex();
    total++;
    if ({redirect_valid, flush, stall} !== 3'b000 || mispredict_count !== 16'd0) begin
      bad++;
      $display("FAIL beq_correct: got v/f/s=%b cnt=%0d, want 000 cnt=0",
               {redirect_valid, flush, stall}, mispredict_count);
    end
    $display("BEQ pc=100 predicted taken, no redirect expected");
  endtask

  task automatic test_bne_redirect();
    redirect_ready = 1;
    set_ex(1, 0, 0, 3'b001, 32'h100, 32'h20, 32'd5, 32'd5, 1);
    tick();
    clear_ex();
    total++;
    if ({redirect_valid, flush, stall} !== 3'b111 || redirect_pc !== 32'h104 ||
        mispredict_count !== 16'd1) begin
      bad++;
      $display("FAIL bne_redirect: got v/f/s=%b pc=%h cnt=%0d, want 111 104 1",
               {redirect_valid, flush, stall}, redirect_pc, mispredict_count);
    end
    tick();
    total++;
    if ({redirect_valid, flush, stall} !== 3'b011) begin
      bad++;
      $display("FAIL bne_drain: got v/f/s=%b, want 011", {redirect_valid, flush, stall});
    end
    tick();
    total++;
    if ({redirect_valid, flush, stall} !== 3'b000 || mispredict_count !== 16'd1) begin
      bad++;
      $display("FAIL bne_idle: got v/f/s=%b cnt=%0d, want 000 1",
               {redirect_valid, flush, stall}, mispredict_count);
    end
    $display("BNE pc=100 mispredict -> redirect 104");
  endtask

  task automatic test_jalr_backpressure();
    redirect_ready = 0;
    set_ex(0, 0, 1, 3'b000, 32'h300, 32'h10, 32'h1001, 32'h0, 0);
    tick();
    // a fresh mispredicting branch must be ignored while busy
    set_ex(1, 0, 0, 3'b001, 32'h500, 32'h40, 32'd1, 32'd2, 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({redirect_valid, flush, stall} !== 3'b111 || redirect_pc !== 32'h1010) begin
        bad++;
        $display("FAIL jalr_hold[%0d]: got v/f/s=%b pc=%h, want 111 1010",
                 i, {redirect_valid, flush, stall}, redirect_pc);
      end
      tick();
    end
    redirect_ready = 1;
    total++;
    if ({redirect_valid, stall} !== 2'b11 || redirect_pc !== 32'h1010) begin
      bad++;
      $display("FAIL jalr_accept: got v/s=%b pc=%h, want 11 1010",
               {redirect_valid, stall}, redirect_pc);
    end
    tick();
    total++;
    if ({redirect_valid, flush, stall} !== 3'b011) begin
      bad++;
      $display("FAIL jalr_drain: got v/f/s=%b, want 011", {redirect_valid, flush, stall});
    end
    clear_ex();
    tick();
    total++;
    if ({redirect_valid, flush, stall} !== 3'b000 || mispredict_count !== 16'd2) begin
      bad++;
      $display("FAIL jalr_idle: got v/f/s=%b cnt=%0d, want 000 2",
               {redirect_valid, flush, stall}, mispredict_count);
    end
    $display("JALR rs1=1001 imm=10 -> redirect 1010 after 3 busy cycles");
  endtask

  task automatic test_blt_bltu();
    redirect_ready = 1;
    set_ex(1, 0, 0, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0);
    tick();
    clear_ex();
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h240) begin
      bad++;
      $display("FAIL blt_signed: got v=%b pc=%h, want 1 240", redirect_valid, redirect_pc);
    end
    tick();
    tick();
    set_ex(1, 0, 0, 3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0);
    tick();
    clear_ex();
    total++;
    if ({redirect_valid, flush, stall} !== 3'b000 || mispredict_count !== 16'd3) begin
      bad++;
      $display("FAIL bltu_unsigned: got v/f/s=%b cnt=%0d, want 000 3",
               {redirect_valid, flush, stall}, mispredict_count);
    end
    $display("BLT -1<1 redirects, BLTU does not");
  endtask

  task automatic test_wrap();
    redirect_ready = 1;
    set_ex(0, 1, 0, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 1);
    tick();
    total++;
    if (redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL jal_predicted: got v=%b, want 0", redirect_valid);
    end
    ex_pred_taken = 0;
    tick();
    clear_ex();
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0004) begin
      bad++;
      $display("FAIL jal_wrap: got v=%b pc=%h, want 1 00000004", redirect_valid, redirect_pc);
    end
    tick();
    tick();
    $display("JAL at FFFFFFFC+8 wraps to 4");
  endtask

  task automatic test_random();
    int nred = 0;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      ex_valid = ($urandom_range(0, 7) != 0);
      ex_is_branch = $urandom_range(0, 1);
      ex_is_jal = ($urandom_range(0, 3) == 0);
      ex_is_jalr = ($urandom_range(0, 4) == 0);
      ex_funct3 = 3'($urandom_range(0, 7));
      ex_pc = {$urandom} & 32'hFFFF_FFFC;
      ex_imm = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) : $urandom;
      ex_rs1 = a;
      ex_rs2 = ($urandom_range(0, 3) == 0) ? a : $urandom;
      ex_pred_taken = $urandom_range(0, 1);
      redirect_ready = ($urandom_range(0, 2) != 0);
      tick();
      total++;
      if (redirect_valid !== m_redir || flush !== (m_redir | m_drain) ||
          stall !== (m_redir | m_drain) || redirect_pc !== m_pc ||
          mispredict_count !== m_cnt) begin
        bad++;
        $display("FAIL random[%0d]: got v/f/s=%b pc=%h cnt=%0d, want %b%b%b %h %0d",
                 i, {redirect_valid, flush, stall}, redirect_pc, mispredict_count,
                 m_redir, m_redir | m_drain, m_redir | m_drain, m_pc, m_cnt);
      end
      if (m_redir && redirect_valid && redirect_pc == m_pc) nred++;
    end
    clear_ex();
    redirect_ready = 1;
    tick();
    tick();
    tick();
    $display("random run: 400 cycles, %0d redirect-busy cycles", nred);
  endtask

  task automatic test_saturate_reset();
    redirect_ready = 0;
    force dut.mispredict_count = 16'hFFFF;
    @(negedge clk);
    release dut.mispredict_count;
    m_cnt = 16'hFFFF;
    #1;
    set_ex(1, 0, 0, 3'b001, 32'h700, 32'h10, 32'd1, 32'd2, 0);
    tick();
    clear_ex();
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h710 || mispredict_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL saturate: got v=%b pc=%h cnt=%h, want 1 710 ffff",
               redirect_valid, redirect_pc, mispredict_count);
    end
    // async reset in the middle of REDIRECT, away from any edge
    #3;
    reset = 1;
    #1;
    total++;
    if ({redirect_valid, flush, stall} !== 3'b000 || redirect_pc !== 32'h0 ||
        mispredict_count !== 16'h0) begin
      bad++;
      $display("FAIL async_reset: got v/f/s=%b pc=%h cnt=%h, want 000 0 0",
               {redirect_valid, flush, stall}, redirect_pc, mispredict_count);
    end
    m_redir = 0; m_drain = 0; m_pc = '0; m_cnt = '0;
    #1;
    reset = 0;
    set_ex(0, 1, 0, 3'b000, 32'h800, 32'h20, 32'h0, 32'h0, 0);
    tick();
    clear_ex();
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h820 || mispredict_count !== 16'd1) begin
      bad++;
      $display("FAIL first_after_reset: got v=%b pc=%h cnt=%0d, want 1 820 1",
               redirect_valid, redirect_pc, mispredict_count);
    end
    $display("saturation and mid-REDIRECT async reset");
  endtask

  initial begin
    test_reset();
    test_beq_correct();
    test_bne_redirect();
    test_jalr_backpressure();
    test_blt_bltu();
    test_wrap();
    test_random();
    test_saturate_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
